slow_tick_rx: RTL and testbench
===============================

Name: slow_tick_rx

Overview:
- Receiving end of the divided-clock interface: consumes a slow divided clock level (the 500 ms / 5 s class of signals) inside the 100 MHz domain.
- Treats `slow_clk` as asynchronous. Synchronizes it, glitch-filters it and edge-detects it into single-cycle `tick` pulses.
- Drives a loadable countdown timer from those ticks. Game logic (spawn delay, power-up duration, respawn countdown) uses it instead of clocking flops directly off divided clocks.

Parameters:
- SYNC_STAGES, 2: synchronizer flop count (min 2).
- STABLE_CYC, 4: consecutive cycles a synchronized level must differ from the accepted level before it is accepted (min 1).
- CNT_W, 10: countdown width.

Ports:
- clk_100mhz  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- slow_clk  in  1  divided clock level, treated as async data, never used as a clock.
- edge_sel  in  2  tick source: 00 none, 01 rising, 10 falling, 11 both.
- load  in  1  load `load_val` into the counter.
- load_val  in  CNT_W  countdown start value.
- start  in  1  begin counting.
- pause  in  1  level; holds count while high.
- level  out  1  filtered, accepted `slow_clk` level.
- tick  out  1  one-cycle pulse per selected accepted edge.
- remaining  out  CNT_W  current count.
- running  out  1  high in RUN and PAUSED.
- expired  out  1  one-cycle pulse when count reaches 0.

Behaviour:
- **Reset:** all of the following hold on the cycle after `rst` is sampled high, with `rst` overriding every other input:
  - sync chain = 0, filter count = 0, `level` = 0, `armed` = 0;
  - `tick` = 0, `expired` = 0, `remaining` = 0, `running` = 0, state = IDLE.
- **Synchronizer and filter:**
  - The last sync stage is compared with `level` each cycle.
  - If it differs, the filter count increments; otherwise the count clears to 0.
  - When the count reaches STABLE_CYC, `level` takes the new value and the count clears.
  - A glitch shorter than STABLE_CYC cycles never changes `level`.
- **Tick generation:**
  - `tick` is registered and asserted in the cycle after `level` changes, if the change matches `edge_sel` and `armed` = 1.
  - The first acceptance after reset only sets `armed` and never ticks, so no spurious edge occurs when `slow_clk` idles high.
  - Latency: `tick` rises SYNC_STAGES+STABLE_CYC+1 edges after the first `clk_100mhz` edge that samples the new `slow_clk` value. Default: 7.
  - `edge_sel` = 00 suppresses ticks; filtering continues.
- **Timer FSM** (states IDLE, RUN, PAUSED, DONE):
  - **IDLE:**
    - `load` → `remaining` = `load_val`, stay IDLE.
    - `start` with `remaining` != 0 → RUN.
    - `start` with `remaining` = 0 is ignored.
  - **RUN:**
    - On `tick`, if `remaining` > 1, decrement.
    - On `tick`, if `remaining` = 1 → `remaining` = 0, `expired` pulses next cycle, go to DONE.
    - `pause` = 1 → PAUSED (takes priority over a coincident `tick`, which is dropped).
  - **PAUSED:**
    - Ticks are ignored.
    - `pause` = 0 → RUN.
  - **DONE:**
    - `start` is ignored.
    - `load` → IDLE with the new value.
  - **Load priority:** `load` in any state aborts to IDLE with `remaining` = `load_val`. `load` beats `start`, `pause` and `tick` in the same cycle.
- **Outputs:** `running` is registered from the state (RUN or PAUSED). The counter never wraps below 0.

Decomposition:
- **Shared clk package:** the state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3) and the `edge_sel` encodings, reused by the other clock consumers.
- **Sub-module `level_filter`:** SYNC_STAGES synchronizer plus STABLE_CYC filter, outputting `level` and a one-cycle `changed` strobe. The timer FSM lives in the top.

Test Plan:
1. **Rising-edge latency:** `rst` 2 cycles, `slow_clk` idle 0, `edge_sel` = 01, raise `slow_clk` → no tick on the first acceptance (arms only). Next 0→1 → `tick` high exactly 7 cycles after sampling, for 1 cycle.
2. **Glitch rejection:** with `level` = 0 and armed, `slow_clk` high for 3 cycles then low → `level` stays 0, no `tick`. Held high for 4 cycles → accepted.
3. **Full countdown:** `load` with `load_val` = 3, `start`, 3 rising ticks → `remaining` 3→2→1→0, `expired` pulses once, state DONE, `running` = 0.
4. **Pause:** `load` 5, `start`, 1 tick (`remaining` = 4), then `pause` = 1 across 2 ticks → stays 4. `pause` = 0, next tick → 3.
5. **Load priority and zero start:**
   - `load` + `start` in the same cycle with `load_val` = 2 → IDLE, `remaining` = 2.
   - `start` with `remaining` = 0 → stays IDLE.
   - `load` during RUN → IDLE with the new value.
6. **Reset mid-run and both edges:**
   - `edge_sel` = 11 → ticks on both edges.
   - `rst` during RUN → all outputs return to their reset values on the cycle after `rst`.
   - The first edge after reset does not tick.

Source files
------------

// File: rtl/slow_tick_rx_pkg.sv
// Shared encodings for consumers of divided slow clocks: timer FSM states and
// tick-edge selection codes.
package slow_tick_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } timer_state_t;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_t;

   // Bit 0 of the select enables rising edges, bit 1 enables falling edges.
   function automatic logic edge_match(input logic [1:0] sel, input logic new_level);
      return new_level ? sel[0] : sel[1];
   endfunction

endpackage

// File: rtl/slow_tick_rx_level_filter.sv
// Synchronizes an asynchronous slow level and accepts a new value only after it
// has differed from the accepted level for STABLE_CYC consecutive cycles.
module level_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CYC  = 4
) (
   input  logic clk_100mhz,
   input  logic rst,
   input  logic slow_clk,
   output logic level,
   output logic changed
);

   localparam int FCW = $clog2(STABLE_CYC + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FCW-1:0]         filt_cnt;

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         sync_q   <= '0;
         filt_cnt <= '0;
         level    <= 1'b0;
         changed  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_clk};
         changed <= 1'b0;
         // The cycle that would bring the count to STABLE_CYC accepts the level instead.
         if (sync_q[SYNC_STAGES-1] != level) begin
            if (filt_cnt == FCW'(STABLE_CYC - 1)) begin
               level    <= sync_q[SYNC_STAGES-1];
               filt_cnt <= '0;
               changed  <= 1'b1;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/slow_tick_rx.sv
// Receives a divided slow clock as data, turns its accepted edges into ticks and
// drives a loadable countdown timer from them.
module slow_tick_rx
   import slow_tick_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CYC  = 4,
   parameter int CNT_W       = 10
) (
   input  logic             clk_100mhz,
   input  logic             rst,
   input  logic             slow_clk,
   input  logic [1:0]       edge_sel,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic             level,
   output logic             tick,
   output logic [CNT_W-1:0] remaining,
   output logic             running,
   output logic             expired
);

   logic         changed;
   logic         armed;
   timer_state_t state;

   level_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CYC (STABLE_CYC)
   ) u_filter (
      .clk_100mhz(clk_100mhz),
      .rst       (rst),
      .slow_clk  (slow_clk),
      .level     (level),
      .changed   (changed)
   );

   // The first acceptance after reset only arms, so an idle-high input never ticks.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         armed <= 1'b0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (changed) begin
            armed <= 1'b1;
            tick  <= armed & edge_match(edge_sel, level);
         end
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state     <= ST_IDLE;
         remaining <= '0;
         running   <= 1'b0;
         expired   <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (load) begin
            state     <= ST_IDLE;
            remaining <= load_val;
            running   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && remaining != '0) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (pause) begin
                     state <= ST_PAUSED;
                  end else if (tick) begin
                     if (remaining == CNT_W'(1)) begin
                        remaining <= '0;
                        expired   <= 1'b1;
                        state     <= ST_DONE;
                        running   <= 1'b0;
                     end else if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                     end
                  end
               end
               ST_PAUSED: begin
                  if (!pause) state <= ST_RUN;
               end
               ST_DONE: begin
                  running <= 1'b0;
               end
               default: begin
                  state   <= ST_IDLE;
                  running <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slow_tick_rx.sv
// Directed bench for slow_tick_rx: tick latency, glitch rejection, countdown,
// pause, load priority and reset behaviour.
module tb_slow_tick_rx;

   localparam int CNT_W = 10;

   logic             clk_100mhz = 1'b0;
   logic             rst = 1'b1;
   logic             slow_clk = 1'b0;
   logic [1:0]       edge_sel = 2'b01;
   logic             load = 1'b0;
   logic [CNT_W-1:0] load_val = '0;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic             level;
   logic             tick;
   logic [CNT_W-1:0] remaining;
   logic             running;
   logic             expired;

   int n_cmp = 0;
   int n_err = 0;

   slow_tick_rx #(
      .SYNC_STAGES(2),
      .STABLE_CYC (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_100mhz(clk_100mhz),
      .rst       (rst),
      .slow_clk  (slow_clk),
      .edge_sel  (edge_sel),
      .load      (load),
      .load_val  (load_val),
      .start     (start),
      .pause     (pause),
      .level     (level),
      .tick      (tick),
      .remaining (remaining),
      .running   (running),
      .expired   (expired)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_100mhz);
   endtask

   // Drive slow_clk to v and watch a fixed window of cycles.
   task automatic apply_level(input logic v, output int first, output int ntick, output int nexp);
      slow_clk = v;
      first = 0; ntick = 0; nexp = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk_100mhz);
         if (tick) begin
            ntick++;
            if (first == 0) first = i;
         end
         if (expired) nexp++;
      end
   endtask

   task automatic glitch(input int len, output int ntick, output int saw_high);
      slow_clk = 1'b1;
      ntick = 0; saw_high = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_100mhz);
         if (i == len) slow_clk = 1'b0;
         if (tick) ntick++;
         if (level) saw_high = 1;
      end
   endtask

   task automatic pulse_in(input int which);
      if (which == 0) load = 1'b1; else start = 1'b1;
      step(1);
      load = 1'b0; start = 1'b0;
   endtask

   int first, ntick, nexp, saw;

   initial begin
      // 1: reset and rising-edge latency
      step(2);
      chk("rst_level", level, 0);
      chk("rst_tick", tick, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_running", running, 0);
      chk("rst_expired", expired, 0);
      rst = 1'b0;
      apply_level(1'b1, first, ntick, nexp);
      chk("arm_no_tick", ntick, 0);
      chk("arm_level", level, 1);
      apply_level(1'b0, first, ntick, nexp);
      chk("fall_no_tick_rise_sel", ntick, 0);
      chk("fall_level", level, 0);
      apply_level(1'b1, first, ntick, nexp);
      chk("rise_latency", first, 7);
      chk("rise_tick_count", ntick, 1);
      chk("idle_remaining", remaining, 0);

      // 2: glitch rejection
      apply_level(1'b0, first, ntick, nexp);
      glitch(3, ntick, saw);
      chk("glitch3_level", saw, 0);
      chk("glitch3_tick", ntick, 0);
      glitch(4, ntick, saw);
      chk("glitch4_level", saw, 1);
      chk("glitch4_tick", ntick, 1);
      chk("glitch4_settle", level, 0);

      // 3: full countdown
      load_val = 10'd3;
      pulse_in(0);
      chk("load3_remaining", remaining, 3);
      chk("load3_running", running, 0);
      pulse_in(1);
      chk("start_running", running, 1);
      apply_level(1'b1, first, ntick, nexp);
      chk("cd_rem2", remaining, 2);
      apply_level(1'b0, first, ntick, nexp);
      apply_level(1'b1, first, ntick, nexp);
      chk("cd_rem1", remaining, 1);
      chk("cd_no_early_exp", nexp, 0);
      apply_level(1'b0, first, ntick, nexp);
      apply_level(1'b1, first, ntick, nexp);
      chk("cd_rem0", remaining, 0);
      chk("cd_expired_once", nexp, 1);
      chk("cd_done_running", running, 0);
      pulse_in(1);
      step(1);
      chk("done_start_ignored", running, 0);

      // 4: pause
      load_val = 10'd5;
      pulse_in(0);
      pulse_in(1);
      apply_level(1'b0, first, ntick, nexp);
      apply_level(1'b1, first, ntick, nexp);
      chk("pause_pre", remaining, 4);
      pause = 1'b1;
      step(1);
      chk("paused_running", running, 1);
      apply_level(1'b0, first, ntick, nexp);
      apply_level(1'b1, first, ntick, nexp);
      chk("paused_tick_seen", ntick, 1);
      apply_level(1'b0, first, ntick, nexp);
      apply_level(1'b1, first, ntick, nexp);
      chk("paused_hold", remaining, 4);
      pause = 1'b0;
      step(1);
      apply_level(1'b0, first, ntick, nexp);
      apply_level(1'b1, first, ntick, nexp);
      chk("resume_dec", remaining, 3);

      // 5: load priority and zero start
      load_val = 10'd2;
      load = 1'b1; start = 1'b1;
      step(1);
      load = 1'b0; start = 1'b0;
      chk("ldst_remaining", remaining, 2);
      chk("ldst_running", running, 0);
      load_val = 10'd0;
      pulse_in(0);
      pulse_in(1);
      step(1);
      chk("zero_start_running", running, 0);
      load_val = 10'd6;
      pulse_in(0);
      pulse_in(1);
      chk("run6_running", running, 1);
      load_val = 10'd9;
      pulse_in(0);
      chk("load_in_run_rem", remaining, 9);
      chk("load_in_run_running", running, 0);

      // 6: both edges, reset mid-run
      edge_sel = 2'b11;
      pulse_in(1);
      apply_level(1'b0, first, ntick, nexp);
      chk("both_fall_latency", first, 7);
      chk("both_fall_rem", remaining, 8);
      apply_level(1'b1, first, ntick, nexp);
      chk("both_rise_rem", remaining, 7);
      chk("run_before_rst", running, 1);
      rst = 1'b1;
      step(1);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_remaining", remaining, 0);
      chk("mid_rst_running", running, 0);
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_expired", expired, 0);
      rst = 1'b0;
      apply_level(1'b1, first, ntick, nexp);
      chk("post_rst_arm_tick", ntick, 0);
      chk("post_rst_level", level, 1);
      apply_level(1'b0, first, ntick, nexp);
      chk("post_rst_fall_tick", first, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
